// File: rtl/pe_pkg.sv
// Shared constants and FSM state encoding for the pe_acc accumulator slice.
package pe_pkg;

    localparam int LANES  = 32;             // int32 product lanes per beat
    localparam int LANE_W = 32;             // width of one lane
    localparam int TREE_N = 8;              // adjacent lanes summed by one tree
    localparam int TREES  = LANES / TREE_N; // number of stage-1 partials
    localparam int PART_W = 35;             // 8 x int32 cannot overflow 35 bits
    localparam int SUM_W  = 37;             // 4 x 35-bit partials cannot overflow 37 bits

    // Final drain-counter value. It spans the two pipeline flush cycles plus
    // the edge that loads the result register.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/pe_acc_tree8.sv
// Combinational adder tree: sums 8 adjacent signed int32 lanes into one
// sign-extended 35-bit partial.
module pe_acc_tree8
    import pe_pkg::*;
(
    input  logic [TREE_N*LANE_W-1:0] lanes_i,
    output logic signed [PART_W-1:0] sum_o
);

    logic signed [PART_W-1:0] acc;

    // Sign-extend each lane to the partial width and add it to the running sum.
    always_comb begin
        // NOTE: blocking '=' because each add must see the running sum from the previous iteration.
        acc = '0;
        for (int i = 0; i < TREE_N; i++) begin
            acc = acc + PART_W'($signed(lanes_i[i*LANE_W +: LANE_W]));
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/pe_acc.sv
// pe_acc: job-based accumulator for beats of 32 signed int32 products.
// A job of inst_len beats is reduced through a 2-stage pipeline (lane-group
// partials, then accumulate). The sum is presented on result until it is
// consumed.
// Build option: define PE_ACC_SAT_EN to clamp the presented result to the
// int32 range. The internal accumulator always wraps.
module pe_acc
    import pe_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_vld,
    input  logic [LEN_W-1:0]        inst_len,
    output logic                    inst_rdy,
    input  logic                    mult_vld,
    input  logic [LANES*LANE_W-1:0] mult_result,
    output logic                    mult_rdy,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_vld,
    input  logic                    result_rdy
);

    state_t                   state_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt_q;
    logic [1:0]               drain_q;
    logic                     inst_rdy_q;
    logic                     mult_rdy_q;
    logic                     result_vld_q;
    logic signed [ACC_W-1:0]  result_q;
    logic signed [ACC_W-1:0]  result_d;

    logic signed [PART_W-1:0] part_d [TREES];
    logic signed [PART_W-1:0] part_q [TREES];
    logic                     s1_vld_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  acc_q;

    logic job_fire;
    logic beat_fire;
    logic last_beat;

    // The ready and valid flags are registered and only ever set in their own
    // state, so they stay mutually exclusive.
    assign job_fire  = inst_vld && inst_rdy_q;
    assign beat_fire = mult_vld && mult_rdy_q;
    assign last_beat = beat_fire && (cnt_q == len_q - LEN_W'(1));

    for (genvar g = 0; g < TREES; g++) begin : g_tree
        pe_acc_tree8 u_tree (
            .lanes_i (mult_result[g*TREE_N*LANE_W +: TREE_N*LANE_W]),
            .sum_o   (part_d[g])
        );
    end

    // Fold the four registered partials into one 37-bit beat sum.
    always_comb begin
        // NOTE: default assignment first, so no path leaves sum_d unassigned (no latch).
        sum_d = '0;
        for (int g = 0; g < TREES; g++) begin
            sum_d = sum_d + SUM_W'(part_q[g]);
        end
    end

`ifdef PE_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sh7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(32'sh8000_0000);

    // Clamp the presented value to the int32 range. The accumulator itself is not clamped.
    always_comb begin
        if (acc_q > SAT_MAX) begin
            result_d = SAT_MAX;
        end else if (acc_q < SAT_MIN) begin
            result_d = SAT_MIN;
        end else begin
            result_d = acc_q;
        end
    end
`else
    assign result_d = acc_q;
`endif

    // Pipeline: stage 1 captures lane-group partials, stage 2 accumulates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the partial array is reset too, so nothing from an aborted job survives a reset.
            for (int g = 0; g < TREES; g++) begin
                part_q[g] <= '0;
            end
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            s1_vld_q <= beat_fire;
            if (beat_fire) begin
                for (int g = 0; g < TREES; g++) begin
                    part_q[g] <= part_d[g];
                end
            end
            if (job_fire) begin
                acc_q <= '0;
            end else if (s1_vld_q) begin
                acc_q <= acc_q + ACC_W'(sum_d);
            end
        end
    end

    // Job-control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking '<=' so every register samples pre-edge values.
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            drain_q      <= '0;
            inst_rdy_q   <= 1'b1;
            mult_rdy_q   <= 1'b0;
            result_vld_q <= 1'b0;
            result_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_fire) begin
                        len_q      <= inst_len;
                        cnt_q      <= '0;
                        drain_q    <= '0;
                        inst_rdy_q <= 1'b0;
                        if (inst_len == '0) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q    <= ST_ACC;
                            mult_rdy_q <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (beat_fire) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_beat) begin
                            state_q    <= ST_DRAIN;
                            mult_rdy_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q      <= ST_OUT;
                        result_vld_q <= 1'b1;
                        result_q     <= result_d;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                ST_OUT: begin
                    if (result_rdy) begin
                        state_q      <= ST_IDLE;
                        result_vld_q <= 1'b0;
                        inst_rdy_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign inst_rdy   = inst_rdy_q;
    assign mult_rdy   = mult_rdy_q;
    assign result_vld = result_vld_q;
    assign result     = result_q;

endmodule

// File: tb/tb_pe_acc.sv
// Self-checking bench for pe_acc. The expected sums come from a plain
// arithmetic model of the beat queue.
`timescale 1ns/1ps
module tb_pe_acc;

    localparam int ACC_W = 48;
    localparam int LEN_W = 8;
    localparam int NB    = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_vld;
    logic [LEN_W-1:0]  inst_len;
    logic              inst_rdy;
    logic              mult_vld;
    logic [NB-1:0]     mult_result;
    logic              mult_rdy;
    logic [ACC_W-1:0]  result;
    logic              result_vld;
    logic              result_rdy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NB-1:0] beat_q[$];

    always #5 clk = ~clk;

    pe_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_vld    (inst_vld),
        .inst_len    (inst_len),
        .inst_rdy    (inst_rdy),
        .mult_vld    (mult_vld),
        .mult_result (mult_result),
        .mult_rdy    (mult_rdy),
        .result      (result),
        .result_vld  (result_vld),
        .result_rdy  (result_rdy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] rand_beat();
        logic [NB-1:0] v;
        for (int l = 0; l < 32; l++) v[l*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic fill_const(input int len, input logic [31:0] val);
        logic [NB-1:0] v;
        beat_q.delete();
        for (int l = 0; l < 32; l++) v[l*32 +: 32] = val;
        for (int b = 0; b < len; b++) beat_q.push_back(v);
    endtask

    task automatic fill_ramp(input int len);
        logic [NB-1:0] v;
        beat_q.delete();
        for (int l = 0; l < 32; l++) v[l*32 +: 32] = 32'(l - 16);
        for (int b = 0; b < len; b++) beat_q.push_back(v);
    endtask

    task automatic fill_rand(input int len);
        beat_q.delete();
        for (int b = 0; b < len; b++) beat_q.push_back(rand_beat());
    endtask

    // Reference: plain sum of every signed lane of every beat, wrapped to ACC_W bits.
    function automatic logic [ACC_W-1:0] model();
        longint        s;
        longint        sw;
        int            w;
        logic [NB-1:0] v;
        logic [ACC_W-1:0] a;
        s = 0;
        foreach (beat_q[b]) begin
            v = beat_q[b];
            for (int l = 0; l < 32; l++) begin
                w = int'(v[l*32 +: 32]);
                s += longint'(w);
            end
        end
        a = s[ACC_W-1:0];
        sw = longint'($signed(a));
`ifdef PE_ACC_SAT_EN
        if (sw > 64'sd2147483647) sw = 64'sd2147483647;
        else if (sw < -64'sd2147483648) sw = -64'sd2147483648;
`endif
        a = sw[ACC_W-1:0];
        return a;
    endfunction

    // Offers one job, then feeds the beats in beat_q until result_vld is seen.
    // Leaves the result pending.
    task automatic do_job(input int len, input int mode, output logic [ACC_W-1:0] res,
                          output int beats, output int lat, output int wait_cyc,
                          output bit mrdy_seen, output bit excl_bad, output bit tmo);
        int idx, cyc, last_cyc;
        bit fire, ph, got;
        idx = 0; cyc = 0; last_cyc = 0; ph = 0; got = 0;
        beats = 0; lat = 0; wait_cyc = 0; mrdy_seen = 0; excl_bad = 0; tmo = 0; res = '0;
        while (inst_rdy !== 1'b1 && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        inst_vld = 1'b1;
        inst_len = LEN_W'(len);
        step();
        inst_vld = 1'b0;
        while (!got && cyc < 4*len + 40) begin
            if ((int'(inst_rdy) + int'(mult_rdy) + int'(result_vld)) > 1) excl_bad = 1;
            if (mult_rdy === 1'b1) mrdy_seen = 1;
            if (result_vld === 1'b1) begin
                got = 1;
                lat = cyc - last_cyc;
                res = result;
            end else begin
                case (mode)
                    0: mult_vld = 1'b1;
                    1: begin mult_vld = ph; ph = ~ph; end
                    default: mult_vld = 1'($urandom_range(0, 1));
                endcase
                mult_result = (idx < beat_q.size()) ? beat_q[idx] : rand_beat();
                fire = mult_vld && mult_rdy;
                step();
                cyc++;
                if (fire) begin
                    beats++;
                    idx++;
                    last_cyc = cyc;
                end
            end
        end
        mult_vld = 1'b0;
        tmo = !got;
    endtask

    // Holds result_rdy low for 'hold' cycles (offering a job meanwhile), then consumes the result.
    task automatic consume(input int hold, output bit unstable, output bit irdy_seen,
                           output logic irdy_after, output logic vld_after);
        logic [ACC_W-1:0] r0;
        r0 = result; unstable = 0; irdy_seen = 0;
        result_rdy = 1'b0;
        inst_vld = (hold > 0);
        inst_len = LEN_W'(1);
        for (int i = 0; i < hold; i++) begin
            step();
            if (result !== r0 || result_vld !== 1'b1) unstable = 1;
            if (inst_rdy !== 1'b0) irdy_seen = 1;
        end
        inst_vld = 1'b0;
        result_rdy = 1'b1;
        step();
        result_rdy = 1'b0;
        irdy_after = inst_rdy;
        vld_after = result_vld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (inst_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_inst_rdy: got %b expected 1", inst_rdy); end
        n_checks++; if (mult_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_mult_rdy: got %b expected 0", mult_rdy); end
        n_checks++; if (result_vld !== 1'b0) begin n_fail++; $display("FAIL reset_result_vld: got %b expected 0", result_vld); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %0h expected 0", result); end
    endtask

    task automatic test_single();
        logic [ACC_W-1:0] res, exp;
        int beats, lat, wc;
        bit ms, eb, tmo, un, is;
        logic ia, va;
        exp = ACC_W'(96);
        fill_const(1, 32'd3);
        do_job(1, 0, res, beats, lat, wc, ms, eb, tmo);
        n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL single_sum: got %0d expected %0d (timeout=%0b)", $signed(res), $signed(exp), tmo); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", lat); end
        n_checks++; if (beats !== 1) begin n_fail++; $display("FAIL single_beats: got %0d expected 1", beats); end
        n_checks++; if (eb) begin n_fail++; $display("FAIL single_exclusive: got overlap expected none"); end
        consume(0, un, is, ia, va);
    endtask

    task automatic test_stall_toggle();
        logic [ACC_W-1:0] res, exp;
        int beats, lat, wc;
        bit ms, eb, tmo, un, is;
        logic ia, va;
        exp = ACC_W'(-64);
        fill_ramp(4);
        do_job(4, 1, res, beats, lat, wc, ms, eb, tmo);
        n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL toggle_sum: got %0d expected %0d", $signed(res), $signed(exp)); end
        n_checks++; if (beats !== 4) begin n_fail++; $display("FAIL toggle_beats: got %0d expected 4", beats); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL toggle_latency: got %0d expected 3", lat); end
        consume(0, un, is, ia, va);
    endtask

    task automatic test_zero_len();
        logic [ACC_W-1:0] res;
        int beats, lat, wc;
        bit ms, eb, tmo, un, is;
        logic ia, va;
        fill_const(0, 32'd0);
        do_job(0, 0, res, beats, lat, wc, ms, eb, tmo);
        n_checks++; if (tmo || res !== '0) begin n_fail++; $display("FAIL zero_sum: got %0d expected 0", $signed(res)); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL zero_latency: got %0d expected 3", lat); end
        n_checks++; if (ms || beats !== 0) begin n_fail++; $display("FAIL zero_mult_rdy: got rdy_seen=%0b beats=%0d expected 0/0", ms, beats); end
        consume(0, un, is, ia, va);
    endtask

    task automatic test_max_len();
        logic [ACC_W-1:0] res, exp;
        longint e;
        int beats, lat, wc;
        bit ms, eb, tmo, un, is;
        logic ia, va;
`ifdef PE_ACC_SAT_EN
        e = 64'd2147483647;
`else
        e = 64'd255 * 64'd32 * 64'd2147483647;
`endif
        exp = e[ACC_W-1:0];
        fill_const(255, 32'h7FFF_FFFF);
        do_job(255, 0, res, beats, lat, wc, ms, eb, tmo);
        n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL max_sum: got %0d expected %0d", $signed(res), $signed(exp)); end
        n_checks++; if (beats !== 255) begin n_fail++; $display("FAIL max_beats: got %0d expected 255", beats); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL max_latency: got %0d expected 3", lat); end
        consume(0, un, is, ia, va);
    endtask

    task automatic test_hold();
        logic [ACC_W-1:0] res, exp;
        int beats, lat, wc, len;
        bit ms, eb, tmo, un, is;
        logic ia, va;
        len = $urandom_range(1, 8);
        fill_rand(len);
        exp = model();
        do_job(len, 2, res, beats, lat, wc, ms, eb, tmo);
        n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL hold_sum: got %0d expected %0d", $signed(res), $signed(exp)); end
        consume(10, un, is, ia, va);
        n_checks++; if (un) begin n_fail++; $display("FAIL hold_stable: got changing result/valid expected stable"); end
        n_checks++; if (is) begin n_fail++; $display("FAIL hold_inst_rdy: got inst_rdy=1 while pending expected 0"); end
        n_checks++; if (ia !== 1'b1 || va !== 1'b0) begin n_fail++; $display("FAIL hold_release: got inst_rdy=%b result_vld=%b expected 1/0", ia, va); end
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] res, exp;
        int beats, lat, wc, len;
        bit ms, eb, tmo, un, is;
        logic ia, va;
        for (int j = 0; j < 3; j++) begin
            len = $urandom_range(1, 6);
            fill_rand(len);
            exp = model();
            do_job(len, 2, res, beats, lat, wc, ms, eb, tmo);
            n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL b2b_accept_wait[%0d]: got %0d expected 0", j, wc); end
            n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %0d expected %0d", j, $signed(res), $signed(exp)); end
            consume(0, un, is, ia, va);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [ACC_W-1:0] res, exp;
        int beats, lat, wc;
        bit ms, eb, tmo, un, is, vld_seen;
        logic ia, va;
        fill_ramp(4);
        wc = 0;
        while (inst_rdy !== 1'b1 && wc < 50) begin step(); wc++; end
        inst_vld = 1'b1; inst_len = LEN_W'(4);
        step();
        inst_vld = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mult_vld = 1'b1; mult_result = beat_q[b];
            step();
        end
        mult_vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (inst_rdy !== 1'b1 || mult_rdy !== 1'b0 || result_vld !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: got inst_rdy=%b mult_rdy=%b result_vld=%b expected 1/0/0", inst_rdy, mult_rdy, result_vld);
        end
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (result_vld !== 1'b0) vld_seen = 1;
        end
        n_checks++; if (vld_seen) begin n_fail++; $display("FAIL midrst_no_result: got result_vld=1 expected 0"); end
        fill_rand(1);
        exp = model();
        do_job(1, 0, res, beats, lat, wc, ms, eb, tmo);
        n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL midrst_next_sum: got %0d expected %0d", $signed(res), $signed(exp)); end
        consume(0, un, is, ia, va);
    endtask

    task automatic test_random();
        logic [ACC_W-1:0] res, exp;
        int beats, lat, wc, len;
        bit ms, eb, tmo, un, is;
        logic ia, va;
        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(1, 16);
            fill_rand(len);
            exp = model();
            do_job(len, 2, res, beats, lat, wc, ms, eb, tmo);
            n_checks++; if (tmo || res !== exp) begin n_fail++; $display("FAIL rand_sum[%0d]: got %0d expected %0d", j, $signed(res), $signed(exp)); end
            n_checks++; if (beats !== len || lat !== 3 || eb) begin
                n_fail++; $display("FAIL rand_proto[%0d]: got beats=%0d lat=%0d overlap=%0b expected %0d/3/0", j, beats, lat, eb, len);
            end
            consume($urandom_range(0, 3), un, is, ia, va);
        end
    endtask

    initial begin
        rst = 1'b1; inst_vld = 1'b0; inst_len = '0;
        mult_vld = 1'b0; mult_result = '0; result_rdy = 1'b0;
        test_reset();
        test_single();
        test_stall_toggle();
        test_zero_len();
        test_max_len();
        test_hold();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pe_acc.md
PE_ACC -- requirements
Module: pe_acc

Interface
- REQ-001: Parameter ACC_W, default 48, accumulator and result width in bits.
- REQ-002: Parameter LEN_W, default 8, width of the beat-count field.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: inst_vld  input  1  a new accumulation job is offered.
- REQ-006: inst_len  input  LEN_W  number of product beats in the job (0..255).
- REQ-007: inst_rdy  output  1  job accepted when inst_vld && inst_rdy.
- REQ-008: mult_vld  input  1  mult_result beat is valid.
- REQ-009: mult_result  input  1024  32 lanes of signed int32 products; lane i is bits [32i+31:32i].
- REQ-010: mult_rdy  output  1  beat accepted when mult_vld && mult_rdy.
- REQ-011: result  output  ACC_W  signed accumulated sum.
- REQ-012: result_vld  output  1  result is valid.
- REQ-013: result_rdy  input  1  result consumed when result_vld && result_rdy.

Function
- REQ-014: The FSM SHALL have states IDLE, ACC, DRAIN, OUT.
- REQ-015: IDLE: inst_rdy=1. On job handshake, latch inst_len, clear the accumulator and beat counter, and go to ACC, or go to DRAIN if inst_len==0.
- REQ-016: ACC: mult_rdy=1 while beat counter < latched len. Each accepted beat increments the counter. Acceptance of beat len-1 moves the FSM to DRAIN.
- REQ-017: mult_vld low in ACC SHALL stall the block with no state change. Beats offered outside ACC SHALL be ignored.
- REQ-018: Stage 1 (registered) SHALL reduce the 32 lanes to 4 sign-extended 35-bit partial sums, each covering 8 adjacent lanes.
- REQ-019: Stage 2 (registered) SHALL add the 4 partials (37-bit, sign-extended) into the ACC_W accumulator; overflow wraps modulo 2^ACC_W.
- REQ-020: DRAIN SHALL last exactly 2 cycles so that all in-flight beats are accumulated, then go to OUT.
- REQ-021: Latency: last beat accepted at edge t -> result_vld=1 after edge t+3. For len==0, job accepted at edge t -> result_vld=1 after edge t+3 with result=0.
- REQ-022: OUT: result_vld=1 and result SHALL be held stable until result_rdy. The handshake edge returns the FSM to IDLE.
- REQ-023: inst_rdy, mult_rdy and result_vld SHALL be mutually exclusive. A job can never be accepted while a result is pending.
- REQ-024: Back-to-back: IDLE is re-entered on the result handshake, and a new job can be accepted on the following edge.

Reset
- REQ-025: rst SHALL force IDLE, accumulator=0, counter=0, pipeline registers=0, inst_rdy=1, mult_rdy=0, result_vld=0, result=0 on the next edge.
- REQ-026: rst asserted mid-job SHALL discard all in-flight beats and any pending result, with no output produced.

Configuration
- REQ-027: Macro PE_ACC_SAT_EN defined: the value presented on result in OUT SHALL be the accumulator clamped to [-2^31, 2^31-1] and sign-extended to ACC_W. The accumulator itself still wraps.
- REQ-028: Macro PE_ACC_SAT_EN undefined: result SHALL equal the raw accumulator.

Structure
- REQ-029: Shared package pe_pkg SHALL hold the lane count (32), lane width (32), partial width (35), and the FSM state encoding.
- REQ-030: One sub-module, pe_acc_tree8, SHALL perform the combinational sum of 8 lanes. pe_acc SHALL instantiate it 4 times.

Verification
- REQ-031: len=1, all lanes = +3 -> result=96, result_vld 3 cycles after the beat handshake.
- REQ-032: len=4, lane i = i-16 in every beat, mult_vld toggling every other cycle -> result=4*(-16)=-64, exactly 4 beats accepted.
- REQ-033: len=0 -> result=0 after 3 cycles; mult_rdy never asserted.
- REQ-034: len=255, all lanes = 0x7FFFFFFF -> result=255*32*(2^31-1) without PE_ACC_SAT_EN; 0x7FFFFFFF sign-extended with PE_ACC_SAT_EN.
- REQ-035: result_rdy held low 10 cycles -> result stable and inst_rdy=0 throughout; next job is accepted on the edge after the handshake.
- REQ-036: rst pulsed after 2 of 4 beats -> returns to IDLE, no result_vld; a following len=1 job returns the correct sum.
